data_mem_arbiter: RTL and testbench

- Two-port arbiter and access sequencer in front of the single-port data memory.
- The memory has an active-low write enable sampled on the falling clock edge, and registers read data on the rising edge.
- Port A serves the core load/store unit; port B serves the display/debug reader.
- Grants are round-robin, one transaction at a time, with a fixed 2-cycle request-to-ack latency and a bounds check on the address.

---
 rtl/data_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin two-port arbiter and access sequencer in front
// of a single-port data memory (active-low write enable sampled on the falling
// edge, read data registered on the rising edge). Each transaction takes
// IDLE -> ACCESS -> RESP, with a bounds check on the address.
module data_mem_arbiter #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] MAX_ADDR   = ADDR_W'('h3E),
  parameter bit                RESET_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  output logic              err_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic              err_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              mem_we_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  // Port encoding for winner / last grant: 0 = A, 1 = B.
  logic              r_last_grant;
  logic              r_winner;
  logic              r_oob;

  logic              r_mem_we_n;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_ack_a;
  logic              r_ack_b;
  logic              r_err_a;
  logic              r_err_b;
  logic              r_busy;

  logic              w_grant_valid;
  logic              w_grant_b;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_in_range;

  // Next-state logic and round-robin grant decision (grants only from IDLE).
  always_comb begin
    w_state_next  = r_state;
    w_grant_valid = 1'b0;
    w_grant_b     = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_a || req_b) begin
          w_grant_valid = 1'b1;
          // On contention the port that did not win last time goes next.
          w_grant_b     = (req_a && req_b) ? ~r_last_grant : req_b;
          w_state_next  = ACCESS;
        end
      end
      ACCESS:  w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Request fields of the port being granted, plus its bounds check.
  always_comb begin
    w_sel_we    = w_grant_b ? we_b    : we_a;
    w_sel_addr  = w_grant_b ? addr_b  : addr_a;
    w_sel_wdata = w_grant_b ? wdata_b : wdata_a;
    w_in_range  = (w_sel_addr <= MAX_ADDR);
  end

  // State register and all registered outputs; acks/errs default to a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= ~RESET_PRIO;
      r_winner     <= 1'b0;
      r_oob        <= 1'b0;
      r_mem_we_n   <= 1'b1;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_ack_a      <= 1'b0;
      r_ack_b      <= 1'b0;
      r_err_a      <= 1'b0;
      r_err_b      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != IDLE);
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      r_err_a <= 1'b0;
      r_err_b <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_winner     <= w_grant_b;
            r_last_grant <= w_grant_b;
            r_oob        <= ~w_in_range;
            if (w_in_range) begin
              // Write enable stays low across the whole ACCESS cycle so the
              // memory sees it at the falling edge.
              r_mem_addr  <= w_sel_addr;
              r_mem_wdata <= w_sel_wdata;
              r_mem_we_n  <= ~w_sel_we;
            end else begin
              // Rejected requests never touch the memory bus.
              r_mem_we_n  <= 1'b1;
            end
          end
        end
        ACCESS: begin
          r_mem_we_n <= 1'b1;
          r_ack_a    <= ~r_winner;
          r_ack_b    <= r_winner;
          r_err_a    <= ~r_winner & r_oob;
          r_err_b    <= r_winner & r_oob;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_we_n  = r_mem_we_n;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign ack_a     = r_ack_a;
  assign ack_b     = r_ack_b;
  assign err_a     = r_err_a;
  assign err_b     = r_err_b;
  assign busy      = r_busy;

  // Read data is only presented to a port during its own error-free ack.
  assign rdata_a = (r_ack_a && !r_err_a) ? mem_rdata : '0;
  assign rdata_b = (r_ack_b && !r_err_b) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: behavioural memory, ack monitor feeding an
// observed queue, and per-scenario tasks comparing it against expectations.
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req_a, we_a, ack_a, err_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic        req_b, we_b, ack_b, err_b;
  logic [31:0] addr_b, wdata_b, rdata_b;
  logic        mem_we_n;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  data_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .err_a(err_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .err_b(err_b), .rdata_b(rdata_b),
    .mem_we_n(mem_we_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct packed {
    logic        port;
    logic        err;
    logic        chk;
    logic [31:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        obs_q[$];
  logic [31:0] mem   [0:63];
  logic [31:0] model [0:63];
  int          checks = 0;
  int          passed = 0;
  int          we_low_cnt = 0;
  int          both_ack_cnt = 0;
  int          bad_rdata_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: write on falling edge with active-low enable, registered read.
  always @(negedge clk) if (mem_we_n === 1'b0) mem[mem_addr[5:0]] <= mem_wdata;
  always @(posedge clk) mem_rdata <= mem[mem_addr[5:0]];

  // Monitor: record every ack and count bus-level events.
  always @(negedge clk) begin
    if (ack_a === 1'b1) obs_q.push_back({1'b0, err_a, 1'b0, rdata_a});
    if (ack_b === 1'b1) obs_q.push_back({1'b1, err_b, 1'b0, rdata_b});
    if (ack_a === 1'b1 && ack_b === 1'b1) both_ack_cnt++;
    if (mem_we_n === 1'b0) we_low_cnt++;
    if ((ack_a === 1'b0 && rdata_a !== 32'h0) || (ack_b === 1'b0 && rdata_b !== 32'h0))
      bad_rdata_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_req(input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    txn_t e;
    int   n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    e.port  = port;
    e.err   = (addr > 32'h3E);
    e.chk   = e.err || !we;
    e.rdata = e.err ? 32'h0 : (we ? 32'h0 : model[addr[5:0]]);
    if (!e.err && we) model[addr[5:0]] = wdata;
    exp_q.push_back(e);
    if (port == 1'b0) begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata; end
    else              begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata; end
    @(posedge clk); #1;
    // Scramble the request after grant; the DUT must have latched it.
    if (port == 1'b0) begin req_a = 1'b0; we_a = $urandom; addr_a = $urandom; wdata_a = $urandom; end
    else              begin req_b = 1'b0; we_b = $urandom; addr_b = $urandom; wdata_b = $urandom; end
  endtask

  task automatic wait_obs(input int n, output bit ok);
    int k = 0;
    while (obs_q.size() < n && k < 60) begin @(negedge clk); k++; end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mem_we_n !== 1'b1) $display("FAIL reset_mem_we_n: got %b expected 1", mem_we_n); else passed++;
    checks++; if ({ack_a, ack_b} !== 2'b00) $display("FAIL reset_ack: got %b expected 00", {ack_a, ack_b}); else passed++;
    checks++; if ({err_a, err_b} !== 2'b00) $display("FAIL reset_err: got %b expected 00", {err_a, err_b}); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_wdata}); else passed++;
    rst_n = 1'b1;
    $display("reset: done");
  endtask

  task automatic test_write_read();
    int  lat;
    int  we0;
    bit  ok;
    txn_t e, o;
    we0 = we_low_cnt;
    drive_req(1'b0, 1'b1, 32'h8, 32'hDEADBEEF);
    lat = 0;
    do begin @(negedge clk); lat++; end while (ack_a !== 1'b1 && lat < 10);
    checks++; if (lat != 2) $display("FAIL write_latency: got %0d cycles expected 2", lat); else passed++;
    drive_req(1'b0, 1'b0, 32'h8, 32'h0);
    wait_obs(2, ok);
    checks++; if (we_low_cnt - we0 != 1) $display("FAIL write_we_n_pulse: got %0d low cycles expected 1", we_low_cnt - we0); else passed++;
    checks++; if (!ok) $display("FAIL write_read_timeout: got %0d acks expected 2", obs_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.port !== e.port || o.err !== e.err || (e.chk && o.rdata !== e.rdata))
        $display("FAIL write_read_txn: got port=%0d err=%0d rdata=%h expected port=%0d err=%0d rdata=%h", o.port, o.err, o.rdata, e.port, e.err, e.rdata);
      else begin passed++; $display("write_read txn: port=%0d err=%0d rdata=%h", o.port, o.err, o.rdata); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_contention();
    bit   ok;
    int   k = 0;
    txn_t e, o;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back({1'b0, 1'b0, 1'b1, model[8]});
    exp_q.push_back({1'b1, 1'b0, 1'b1, model[16]});
    exp_q.push_back({1'b0, 1'b0, 1'b1, model[8]});
    req_a = 1'b1; we_a = 1'b0; addr_a = 32'h8;
    req_b = 1'b1; we_b = 1'b0; addr_b = 32'h10;
    while (obs_q.size() < 3 && k < 40) begin @(negedge clk); k++; end
    req_a = 1'b0; req_b = 1'b0;
    ok = (obs_q.size() >= 3);
    checks++; if (!ok) $display("FAIL contention_timeout: got %0d acks expected 3", obs_q.size()); else passed++;
    repeat (4) @(negedge clk);
    checks++; if (obs_q.size() != 3) $display("FAIL contention_count: got %0d acks expected 3", obs_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.port !== e.port || o.err !== e.err || (e.chk && o.rdata !== e.rdata))
        $display("FAIL contention_txn: got port=%0d err=%0d rdata=%h expected port=%0d err=%0d rdata=%h", o.port, o.err, o.rdata, e.port, e.err, e.rdata);
      else begin passed++; $display("contention txn: port=%0d err=%0d rdata=%h", o.port, o.err, o.rdata); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_out_of_range();
    bit   ok;
    int   we0;
    txn_t e, o;
    we0 = we_low_cnt;
    drive_req(1'b1, 1'b1, 32'h40, 32'h1234);
    drive_req(1'b1, 1'b0, 32'hFFFFFFFC, 32'h0);
    wait_obs(2, ok);
    checks++; if (we_low_cnt != we0) $display("FAIL oob_we_n: got %0d low cycles expected 0", we_low_cnt - we0); else passed++;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    wait_obs(3, ok);
    checks++; if (!ok) $display("FAIL oob_timeout: got %0d acks expected 3", obs_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.port !== e.port || o.err !== e.err || (e.chk && o.rdata !== e.rdata))
        $display("FAIL oob_txn: got port=%0d err=%0d rdata=%h expected port=%0d err=%0d rdata=%h", o.port, o.err, o.rdata, e.port, e.err, e.rdata);
      else begin passed++; $display("oob txn: port=%0d err=%0d rdata=%h", o.port, o.err, o.rdata); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_boundary();
    bit   ok;
    txn_t e, o;
    drive_req(1'b0, 1'b1, 32'h3E, 32'hA5A55A5A);
    drive_req(1'b0, 1'b0, 32'h3E, 32'h0);
    drive_req(1'b1, 1'b0, 32'h3E, 32'h0);
    wait_obs(3, ok);
    checks++; if (!ok) $display("FAIL boundary_timeout: got %0d acks expected 3", obs_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.port !== e.port || o.err !== e.err || (e.chk && o.rdata !== e.rdata))
        $display("FAIL boundary_txn: got port=%0d err=%0d rdata=%h expected port=%0d err=%0d rdata=%h", o.port, o.err, o.rdata, e.port, e.err, e.rdata);
      else begin passed++; $display("boundary txn: port=%0d err=%0d rdata=%h", o.port, o.err, o.rdata); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    bit   ok;
    int   n = 0;
    txn_t e, o;
    @(negedge clk);
    while (busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'h4; wdata_a = 32'h55;
    model[4] = 32'h55;
    @(posedge clk); #1;
    req_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (obs_q.size() != 0) $display("FAIL reset_mid_ack: got %0d acks expected 0", obs_q.size()); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_mid_busy: got %b expected 0", busy); else passed++;
    checks++; if (mem_we_n !== 1'b1) $display("FAIL reset_mid_we_n: got %b expected 1", mem_we_n); else passed++;
    rst_n = 1'b1;
    obs_q.delete();
    drive_req(1'b0, 1'b0, 32'h4, 32'h0);
    wait_obs(1, ok);
    checks++; if (!ok) $display("FAIL reset_mid_timeout: got %0d acks expected 1", obs_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.port !== e.port || o.err !== e.err || (e.chk && o.rdata !== e.rdata))
        $display("FAIL reset_mid_txn: got port=%0d err=%0d rdata=%h expected port=%0d err=%0d rdata=%h", o.port, o.err, o.rdata, e.port, e.err, e.rdata);
      else begin passed++; $display("reset_mid txn: port=%0d err=%0d rdata=%h", o.port, o.err, o.rdata); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]   = 32'hC0DE0000 | 32'(i);
      model[i] = 32'hC0DE0000 | 32'(i);
    end
    rst_n = 1'b0;
    req_a = 1'b0; we_a = 1'b0; addr_a = 32'h0; wdata_a = 32'h0;
    req_b = 1'b0; we_b = 1'b0; addr_b = 32'h0; wdata_b = 32'h0;
    test_reset();
    test_write_read();
    test_contention();
    test_out_of_range();
    test_boundary();
    test_reset_mid();
    checks++; if (both_ack_cnt != 0) $display("FAIL dual_ack: got %0d cycles expected 0", both_ack_cnt); else passed++;
    checks++; if (bad_rdata_cnt != 0) $display("FAIL rdata_idle: got %0d nonzero cycles expected 0", bad_rdata_cnt); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
